fifo_wr_arbiter: RTL

//  Shares one fifo_bh instance between NUM_REQ producers. Round-robin, burst-locked write arbitration.

---
 rtl/fifo_wr_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked write arbiter in front of one fifo_bh, with read guard.
// Define FIFO_ARB_OCC_EN to build the registered occupancy counter on occ_o.
module fifo_wr_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int REQ_LG2        = 2,
  parameter int DATA_WIDTH     = 986,
  parameter int BURST_LEN      = 4,
  parameter int BURST_LG2      = 2,
  parameter int FIFO_DEPTH_LG2 = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  input  logic                          fifo_empty_i,
  output logic                          fifo_wren_o,
  output logic [DATA_WIDTH-1:0]         fifo_wdata_o,
  input  logic                          rd_req_i,
  output logic                          fifo_rden_o,
  output logic                          grant_valid_o,
  output logic [REQ_LG2-1:0]            grant_id_o,
  output logic [FIFO_DEPTH_LG2:0]       occ_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [REQ_LG2-1:0]   gnt_q, gnt_d;
  logic [REQ_LG2-1:0]   last_q, last_d;
  logic [REQ_LG2-1:0]   pick, idx;
  logic                 found;
  logic [BURST_LG2-1:0] beat_q, beat_d;
  logic                 busy, g_valid, xfer, last_beat;

  assign busy      = (state_q == BUSY);
  assign g_valid   = req_valid_i[gnt_q];
  assign xfer      = busy & g_valid & !fifo_full_i;
  assign last_beat = (beat_q == BURST_LG2'(BURST_LEN - 1));

  // Scan starts one past the last winner so every producer gets a turn.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = REQ_LG2'((int'(last_q) + i) % NUM_REQ);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          gnt_d   = pick;
          last_d  = pick;
          beat_d  = '0;
        end
      end
      BUSY: begin
        if (xfer) begin
          if (last_beat) begin
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else if (!g_valid) begin
          state_d = IDLE;
          beat_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= REQ_LG2'(NUM_REQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (busy) req_ready_o[gnt_q] = !fifo_full_i;
  end

  assign fifo_wren_o   = xfer;
  assign fifo_wdata_o  = xfer ? req_data_i[gnt_q*DATA_WIDTH +: DATA_WIDTH]
                              : '0;
  assign grant_valid_o = busy;
  assign grant_id_o    = gnt_q;
  // Read strobe is also held low while reset is asserted.
  assign fifo_rden_o   = rd_req_i & !fifo_empty_i & reset_n;

`ifdef FIFO_ARB_OCC_EN
  localparam int OW = FIFO_DEPTH_LG2 + 1;
  localparam logic [OW-1:0] OCC_MAX = OW'(2 ** FIFO_DEPTH_LG2);

  logic [OW-1:0] occ_q, occ_d;

  always_comb begin
    occ_d = occ_q;
    if (fifo_wren_o && !fifo_rden_o && occ_q != OCC_MAX)
      occ_d = occ_q + 1'b1;
    else if (fifo_rden_o && !fifo_wren_o && occ_q != '0)
      occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) occ_q <= '0;
    else          occ_q <= occ_d;
  end

  assign occ_o = occ_q;
`else
  assign occ_o = '0;
`endif

endmodule
